// File: rtl/wb_axi_writer.sv
// Write-back engine: turns one 256-bit cache line from the write buffer into an
// 8-beat INCR AXI write burst and reports completion with a one-cycle pulse.
module wb_axi_writer #(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'h1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_wen_i,
    input  logic [31:0]     wb_awaddr_i,
    input  logic [255:0]    wb_wdata_i,
    output logic            wb_bvalid_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]      r_state;
    logic [31:0]     r_addr;
    logic [255:0]    r_data;
    logic [ID_W-1:0] r_awid;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_wlast;
    logic [31:0]     r_wdata;
    logic [2:0]      r_beat;
    logic            r_err;

    logic [2:0]      w_nextBeat;
    logic            w_unused;

    assign w_nextBeat = r_beat + 3'd1;
    // The response ID and the sub-line address bits carry no information here.
    assign w_unused   = ^{bid, wb_awaddr_i[4:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_awid    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_wdata   <= '0;
            r_beat    <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wb_wen_i) begin
                        r_addr    <= {wb_awaddr_i[31:5], 5'b0};
                        r_data    <= wb_wdata_i;
                        r_awid    <= AXI_ID;
                        r_awvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    // First data beat is staged in the same edge the address is accepted.
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wdata   <= r_data[31:0];
                        r_wlast   <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (r_wvalid && wready) begin
                        if (r_beat == 3'd7) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_state  <= RESP;
                        end else begin
                            r_beat  <= w_nextBeat;
                            r_wdata <= r_data[{w_nextBeat, 5'b00000} +: 32];
                            r_wlast <= (w_nextBeat == 3'd7);
                        end
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) begin
                            r_err <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign awid        = r_awid;
    assign awaddr      = r_addr;
    assign awlen       = 8'd7;
    assign awsize      = 3'b010;
    assign awburst     = 2'b01;
    assign awvalid     = r_awvalid;
    assign wdata       = r_wdata;
    assign wstrb       = r_wvalid ? 4'hF : 4'h0;
    assign wlast       = r_wlast;
    assign wvalid      = r_wvalid;
    assign bready      = (r_state == RESP);
    assign wb_bvalid_o = (r_state == DONE);
    assign busy_o      = (r_state != IDLE);
    assign err_o       = r_err;

endmodule

// File: tb/tb_wb_axi_writer.sv
// Directed bench for wb_axi_writer: the bench plays the AXI slave and checks
// every burst beat by beat against hand-chosen line contents.
module tb_wb_axi_writer;

    logic         clk;
    logic         rst;
    logic         wb_wen_i;
    logic [31:0]  wb_awaddr_i;
    logic [255:0] wb_wdata_i;
    logic         wb_bvalid_o;
    logic         busy_o;
    logic         err_o;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int checkCount = 0;
    int errCount   = 0;
    int pulseCount = 0;

    wb_axi_writer #(.ID_W(4), .AXI_ID(4'h1)) dut (
        .clk(clk), .rst(rst),
        .wb_wen_i(wb_wen_i), .wb_awaddr_i(wb_awaddr_i), .wb_wdata_i(wb_wdata_i),
        .wb_bvalid_o(wb_bvalid_o), .busy_o(busy_o), .err_o(err_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_bvalid_o) pulseCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] makeLine(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] line;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = base + step * k;
        return line;
    endfunction

    // Drives one line write and plays the slave; called at a negedge in IDLE,
    // or in DONE when fromDone is set (back-to-back case).
    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [31:0] expAddr,
                                 input logic [31:0] base, input logic [31:0] step,
                                 input int awDelay, input bit wToggle, input int bDelay,
                                 input logic [1:0] resp, input bit expErr,
                                 input bit holdWen, input bit fromDone, input bit toggleWen);
        int  beat;
        int  cyc;
        bit  rdy;
        $display("[TB] burst %s", name);
        wb_wen_i    = 1'b1;
        wb_awaddr_i = addr;
        wb_wdata_i  = makeLine(base, step);
        @(negedge clk);
        if (fromDone) begin
            checkOutput({name, ".idleBusy"}, 64'(busy_o), 64'd0);
            checkOutput({name, ".idlePulse"}, 64'(wb_bvalid_o), 64'd0);
            @(negedge clk);
        end
        if (!holdWen) wb_wen_i = 1'b0;

        checkOutput({name, ".awvalid"}, 64'(awvalid), 64'd1);
        checkOutput({name, ".awaddr"}, 64'(awaddr), 64'(expAddr));
        checkOutput({name, ".awid"}, 64'(awid), 64'h1);
        checkOutput({name, ".awlen"}, 64'(awlen), 64'd7);
        checkOutput({name, ".awsize"}, 64'(awsize), 64'd2);
        checkOutput({name, ".awburst"}, 64'(awburst), 64'd1);
        checkOutput({name, ".addrBusy"}, 64'(busy_o), 64'd1);
        checkOutput({name, ".addrWvalid"}, 64'(wvalid), 64'd0);
        for (int i = 0; i < awDelay; i++) begin
            awready = 1'b0;
            @(negedge clk);
            checkOutput({name, ".awHold"}, 64'(awvalid), 64'd1);
            checkOutput({name, ".awAddrHold"}, 64'(awaddr), 64'(expAddr));
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        checkOutput({name, ".awDrop"}, 64'(awvalid), 64'd0);

        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 100) begin
            if (toggleWen) begin
                wb_wen_i    = cyc[0];
                wb_awaddr_i = $urandom;
                wb_wdata_i  = {8{$urandom}};
            end
            checkOutput({name, ".wvalid"}, 64'(wvalid), 64'd1);
            checkOutput({name, ".wdata"}, 64'(wdata), 64'(base + step * beat));
            checkOutput({name, ".wlast"}, 64'(wlast), 64'(beat == 7));
            checkOutput({name, ".wstrb"}, 64'(wstrb), 64'hF);
            checkOutput({name, ".dataAwaddr"}, 64'(awaddr), 64'(expAddr));
            rdy    = wToggle ? (cyc % 2 == 0) : 1'b1;
            wready = rdy;
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        wready = 1'b0;
        if (!holdWen) wb_wen_i = 1'b0;
        checkOutput({name, ".beats"}, 64'(beat), 64'd8);
        checkOutput({name, ".dataCycles"}, 64'(cyc), wToggle ? 64'd15 : 64'd8);
        checkOutput({name, ".respWvalid"}, 64'(wvalid), 64'd0);
        checkOutput({name, ".respWlast"}, 64'(wlast), 64'd0);
        checkOutput({name, ".bready"}, 64'(bready), 64'd1);

        for (int i = 0; i < bDelay; i++) begin
            @(negedge clk);
            checkOutput({name, ".breadyHold"}, 64'(bready), 64'd1);
            checkOutput({name, ".noEarlyPulse"}, 64'(wb_bvalid_o), 64'd0);
        end
        bvalid = 1'b1;
        bresp  = resp;
        bid    = 4'h5;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        checkOutput({name, ".pulse"}, 64'(wb_bvalid_o), 64'd1);
        checkOutput({name, ".doneBready"}, 64'(bready), 64'd0);
        checkOutput({name, ".err"}, 64'(err_o), 64'(expErr));
        if (!holdWen) begin
            @(negedge clk);
            checkOutput({name, ".pulseEnd"}, 64'(wb_bvalid_o), 64'd0);
            checkOutput({name, ".idle"}, 64'(busy_o), 64'd0);
            checkOutput({name, ".errSticky"}, 64'(err_o), 64'(expErr));
        end
    endtask

    initial begin
        rst         = 1'b1;
        wb_wen_i    = 1'b0;
        wb_awaddr_i = '0;
        wb_wdata_i  = '0;
        awready     = 1'b0;
        wready      = 1'b0;
        bid         = '0;
        bresp       = 2'b00;
        bvalid      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.awvalid", 64'(awvalid), 64'd0);
        checkOutput("rst.wvalid", 64'(wvalid), 64'd0);
        checkOutput("rst.busy", 64'(busy_o), 64'd0);
        checkOutput("rst.err", 64'(err_o), 64'd0);
        checkOutput("rst.awaddr", 64'(awaddr), 64'd0);
        checkOutput("rst.awid", 64'(awid), 64'd0);
        checkOutput("rst.awlen", 64'(awlen), 64'd7);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("ideal", 32'h1FC0_0013, 32'h1FC0_0000, 32'h0, 32'h1111_1111, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("ideal.pulses", 64'(pulseCount), 64'd1);

        applyStimulus("backpressure", 32'h0000_1234, 32'h0000_1220, 32'hA5A5_0000, 32'h0000_0101, 3, 1, 5, 2'b00, 0, 0, 0, 0);
        checkOutput("backpressure.pulses", 64'(pulseCount), 64'd2);

        applyStimulus("b2bFirst", 32'h8000_0040, 32'h8000_0040, 32'hC000_0000, 32'h0000_0010, 0, 0, 1, 2'b00, 0, 1, 0, 0);
        applyStimulus("b2bSecond", 32'h8000_0060, 32'h8000_0060, 32'hD000_0000, 32'h0000_0020, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        checkOutput("b2b.pulses", 64'(pulseCount), 64'd4);

        applyStimulus("ignored", 32'h0000_0BEF, 32'h0000_0BE0, 32'h1234_5678, 32'h0101_0101, 0, 0, 2, 2'b00, 0, 0, 0, 1);
        applyStimulus("slverr", 32'h4000_0000, 32'h4000_0000, 32'hFFFF_0000, 32'h0000_0001, 1, 0, 0, 2'b10, 1, 0, 0, 0);
        applyStimulus("okayAfterErr", 32'h4000_0020, 32'h4000_0020, 32'h0F0F_0F0F, 32'h1000_0000, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        checkOutput("err.pulses", 64'(pulseCount), 64'd7);

        // Reset in the middle of the data phase, after beats 0..3 were accepted.
        $display("[TB] burst midReset");
        wb_wen_i    = 1'b1;
        wb_awaddr_i = 32'h2000_0080;
        wb_wdata_i  = makeLine(32'h5555_0000, 32'h0000_0001);
        awready     = 1'b1;
        wready      = 1'b1;
        @(negedge clk);
        wb_wen_i = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midReset.beat4", 64'(wdata), 64'h5555_0004);
        rst = 1'b1;
        #1;
        checkOutput("midReset.wvalid", 64'(wvalid), 64'd0);
        checkOutput("midReset.wlast", 64'(wlast), 64'd0);
        checkOutput("midReset.awvalid", 64'(awvalid), 64'd0);
        checkOutput("midReset.busy", 64'(busy_o), 64'd0);
        checkOutput("midReset.err", 64'(err_o), 64'd0);
        checkOutput("midReset.wdata", 64'(wdata), 64'd0);
        awready = 1'b0;
        wready  = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        bvalid = 1'b1;
        repeat (3) @(negedge clk);
        bvalid = 1'b0;
        checkOutput("midReset.idle", 64'(busy_o), 64'd0);
        checkOutput("midReset.bready", 64'(bready), 64'd0);
        checkOutput("midReset.pulses", 64'(pulseCount), 64'd7);

        applyStimulus("afterReset", 32'h2000_009F, 32'h2000_0080, 32'h6666_0000, 32'h0000_0003, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("final.pulses", 64'(pulseCount), 64'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, errCount);
        $finish;
    end

endmodule
